butterfly_seq: RTL and testbench
================================

# butterfly_seq

Sequencer for the radix-2 butterfly stage of the FFT datapath. It accepts one complex operand pair (A, B), drives a single shared combinational complex subtractor twice, and returns both butterfly outputs: sum = A + B, computed as A − (−B), and diff = A − B. It sits between the operand fetch logic and the shared subtractor, so one subtractor serves both butterfly legs. Upstream and downstream use valid/ready handshakes.

## Interface
Parameters:
- W, 8, bit width of each real and imaginary component (two's complement).
- CNT_W, 8, width of the completed-butterfly counter.

Ports (complex words packed as real in [2W-1:W], imaginary in [W-1:0]):
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  block can accept an operand pair.
- i_A  input  2W  operand A.
- i_B  input  2W  operand B.
- o_sub_A  output  2W  minuend to the shared complex subtractor.
- o_sub_B  output  2W  subtrahend to the shared complex subtractor.
- i_sub_diff  input  2W  subtractor result, combinational from o_sub_A/o_sub_B.
- o_valid  output  1  o_sum and o_diff are valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  2W  A + B.
- o_diff  output  2W  A − B.
- o_busy  output  1  a transaction is in flight (state ≠ IDLE).
- o_done_cnt  output  CNT_W  count of completed output handshakes; wraps.

## Operation
- FSM states: IDLE, SUM, DIFF, OUT.
- IDLE:
  - o_ready=1.
  - On i_valid: latch i_A → a_reg and i_B → b_reg, then go to SUM.
- SUM:
  - o_sub_A=a_reg; o_sub_B=neg(b_reg).
  - Capture i_sub_diff → o_sum at the edge, then go to DIFF.
- DIFF:
  - o_sub_A=a_reg; o_sub_B=b_reg.
  - Capture i_sub_diff → o_diff at the edge, then go to OUT.
- OUT:
  - o_valid=1.
  - On i_ready: increment o_done_cnt and go to IDLE. Otherwise hold.
- neg() negates each component independently in two's complement, modulo 2^W, with no carry between real and imaginary. neg(−2^(W−1)) = −2^(W−1).
- All arithmetic wraps modulo 2^W per component. No saturation and no overflow flag.
- o_sub_A and o_sub_B are 0 in IDLE and OUT.
- o_ready=0 in SUM, DIFF and OUT. i_valid is ignored in those states, and no operands are latched.
- o_sum and o_diff hold their last values until overwritten, including through IDLE.
- o_done_cnt wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (asynchronous assert, synchronous release to the next edge):
  - state=IDLE.
  - a_reg, b_reg, o_sum, o_diff, o_done_cnt = 0.
  - o_valid=0, o_busy=0, o_ready=1, o_sub_A=o_sub_B=0.
- Latency: accept at edge e (IDLE with i_valid=1); o_sum captured at e+1; o_diff captured at e+2; o_valid high from e+2.
- Output handshake completes at the first edge with o_valid=1 and i_ready=1. o_valid drops after that edge.
- Peak throughput is one butterfly per 4 cycles: accept, SUM, DIFF, OUT with i_ready=1.
- o_ready, o_valid, o_busy and o_sub_* are decoded combinationally from state and registers. None of them depends combinationally on i_valid or i_ready.
- Reset asserted mid-transaction: the transaction is abandoned with no o_valid pulse, o_done_cnt is not incremented, and all registers return to their reset values immediately.
- i_A and i_B may change freely after the accept edge without affecting the result.

## Test plan
- Basic:
  - Stimulus: A=(4,33), B=(2,36), i_ready=1.
  - Required: o_sum=(6,69)=0x0645; o_diff=(2,−3)=0x02FD; o_valid for exactly 1 cycle, high from the accept edge+2; o_done_cnt=1.
- Negatives:
  - Stimulus: A=(0xFF,0xFE), B=(0xFE,0x05).
  - Required: o_sum=(0xFD,0x03); o_diff=(0x01,0xF9).
- Wrap at the negation corner:
  - Stimulus: A=(0x7F,0x00), B=(0x01,0x80).
  - Required: o_sum=(0x80,0x80); o_diff=(0x7E,0x80); no carry between components.
- Back-pressure:
  - Stimulus: hold i_ready=0 for 5 cycles in OUT and pulse i_valid with new operands.
  - Required: o_valid stays 1; o_sum and o_diff are stable; o_ready=0; the new operands are not latched. Raising i_ready completes exactly one handshake.
- Reset mid-operation:
  - Stimulus: deassert i_rst_n during DIFF.
  - Required: outputs go to their reset values without waiting for a clock edge; no o_valid; o_done_cnt unchanged at 0.
- Counter wrap:
  - Stimulus: CNT_W=2, four back-to-back butterflies with i_ready=1.
  - Required: o_done_cnt sequence 1,2,3,0; accept edges spaced 4 cycles apart.

Source files
------------

// File: rtl/butterfly_seq.sv
// butterfly_seq: drives one shared complex subtractor twice per operand pair
// to produce both radix-2 butterfly outputs, sum = A - (-B) and diff = A - B.
module butterfly_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2*W-1:0]   i_A,
    input  logic [2*W-1:0]   i_B,
    output logic [2*W-1:0]   o_sub_A,
    output logic [2*W-1:0]   o_sub_B,
    input  logic [2*W-1:0]   i_sub_diff,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [2*W-1:0]   o_sum,
    output logic [2*W-1:0]   o_diff,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_done_cnt
);
    typedef enum logic [1:0] {IDLE, SUM, DIFF, OUT} state_t;
    state_t           r_state;
    logic [2*W-1:0]   r_a, r_b, r_sum, r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   w_neg_b;
    // per-component negation, no carry from imaginary into real
    assign w_neg_b = {-r_b[2*W-1:W], -r_b[W-1:0]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_valid) begin
                    r_a     <= i_A;
                    r_b     <= i_B;
                    r_state <= SUM;
                end
                SUM: begin
                    r_sum   <= i_sub_diff;
                    r_state <= DIFF;
                end
                DIFF: begin
                    r_diff  <= i_sub_diff;
                    r_state <= OUT;
                end
                OUT: if (i_ready) begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_ready    = r_state == IDLE;
    assign o_valid    = r_state == OUT;
    assign o_busy     = r_state != IDLE;
    assign o_sub_A    = (r_state == SUM || r_state == DIFF) ? r_a : '0;
    assign o_sub_B    = r_state == SUM ? w_neg_b : r_state == DIFF ? r_b : '0;
    assign o_sum      = r_sum;
    assign o_diff     = r_diff;
    assign o_done_cnt = r_cnt;
endmodule

// File: tb/tb_butterfly_seq.sv
// tb_butterfly_seq: directed butterflies checked against a per-component arithmetic model.
module tb_butterfly_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready, o_ready, o_valid, o_busy;
    logic [15:0] i_A, i_B, o_sub_A, o_sub_B, i_sub_diff, o_sum, o_diff;
    logic [1:0]  o_done_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // external shared subtractor: per-component wrap, no cross-carry
    assign i_sub_diff = {o_sub_A[15:8] - o_sub_B[15:8], o_sub_A[7:0] - o_sub_B[7:0]};

    butterfly_seq #(.W(8), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_A(i_A), .i_B(i_B), .o_sub_A(o_sub_A), .o_sub_B(o_sub_B),
        .i_sub_diff(i_sub_diff), .o_valid(o_valid), .i_ready(i_ready),
        .o_sum(o_sum), .o_diff(o_diff), .o_busy(o_busy), .o_done_cnt(o_done_cnt)
    );

    function automatic logic [15:0] cadd(input logic [15:0] a, input logic [15:0] b);
        return {a[15:8] + b[15:8], a[7:0] + b[7:0]};
    endfunction

    function automatic logic [15:0] csub(input logic [15:0] a, input logic [15:0] b);
        return {a[15:8] - b[15:8], a[7:0] - b[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // model: result of the last accepted pair, handshake count, accept edge index
    logic [15:0] m_sum, m_diff;
    logic [1:0]  m_cnt;
    int          m_edges = 0;
    int          m_acc   = 0;
    logic        p_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum  <= '0;
            m_diff <= '0;
            m_cnt  <= '0;
        end else begin
            m_edges <= m_edges + 1;
            if (o_ready && i_valid) begin
                m_sum  <= cadd(i_A, i_B);
                m_diff <= csub(i_A, i_B);
                m_acc  <= m_edges + 1;
            end
            if (o_valid && i_ready) m_cnt <= m_cnt + 2'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_busy", {31'd0, o_ready}, {31'd0, !o_busy});
            chk("done_cnt", {30'd0, o_done_cnt}, {30'd0, m_cnt});
            if (o_ready || o_valid) begin
                chk("sub_idle", {o_sub_A, o_sub_B}, 32'd0);
                chk("sum", {16'd0, o_sum}, {16'd0, m_sum});
                chk("diff", {16'd0, o_diff}, {16'd0, m_diff});
            end
            if (o_valid && !p_valid) chk("latency", m_edges - m_acc, 32'd2);
            p_valid <= o_valid;
        end else begin
            p_valid <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bfly(input logic [15:0] a, input logic [15:0] b, input logic [15:0] es,
                        input logic [15:0] ed, input int hold, input logic [1:0] ecnt);
        logic [15:0] s0, d0;
        i_valid = 1'b1; i_A = a; i_B = b; i_ready = 1'b0;
        step();
        i_valid = 1'b0; i_A = 16'($urandom); i_B = 16'($urandom);
        step();
        chk("valid_e1", {31'd0, o_valid}, 32'd0);
        step();
        chk("valid_e2", {31'd0, o_valid}, 32'd1);
        chk("lit_sum", {16'd0, o_sum}, {16'd0, es});
        chk("lit_diff", {16'd0, o_diff}, {16'd0, ed});
        s0 = o_sum; d0 = o_diff;
        for (int k = 0; k < hold; k++) begin
            i_valid = 1'b1; i_A = 16'($urandom); i_B = 16'($urandom);
            step();
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_stable", {o_sum, o_diff}, {s0, d0});
        end
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("valid_after_hs", {31'd0, o_valid}, 32'd0);
        chk("lit_cnt", {30'd0, o_done_cnt}, {30'd0, ecnt});
    endtask

    initial begin
        int acc_idx[$];
        logic acc;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_A = '0; i_B = '0;
        step();
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid_busy", {30'd0, o_valid, o_busy}, 32'd0);
        chk("rst_regs", {o_sum, o_diff}, 32'd0);
        chk("rst_sub", {o_sub_A, o_sub_B}, 32'd0);
        chk("rst_cnt", {30'd0, o_done_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        bfly(16'h0421, 16'h0224, 16'h0645, 16'h02FD, 0, 2'd1);
        bfly(16'hFFFE, 16'hFE05, 16'hFD03, 16'h01F9, 0, 2'd2);
        bfly(16'h7F00, 16'h0180, 16'h8080, 16'h7E80, 0, 2'd3);
        bfly(16'h1020, 16'h0304, 16'h1324, 16'h0D1C, 5, 2'd0);
        // abandon a transaction while in DIFF
        i_valid = 1'b1; i_A = 16'h5566; i_B = 16'h1122;
        step();
        i_valid = 1'b0;
        step();
        chk("mid_busy", {31'd0, o_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_valid_busy", {30'd0, o_valid, o_busy}, 32'd0);
        chk("mid_rst_regs", {o_sum, o_diff}, 32'd0);
        chk("mid_rst_sub", {o_sub_A, o_sub_B}, 32'd0);
        chk("mid_rst_cnt", {30'd0, o_done_cnt}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("mid_rst_no_valid", {31'd0, o_valid}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        // back-to-back butterflies to wrap the 2-bit counter
        i_valid = 1'b1; i_ready = 1'b1; i_A = 16'h1234; i_B = 16'h0101;
        for (int k = 0; k < 16; k++) begin
            acc = o_ready;
            step();
            if (acc) acc_idx.push_back(k);
            if (k % 4 == 3) chk("wrap_cnt", {30'd0, o_done_cnt}, 32'((k / 4 + 1) % 4));
        end
        i_valid = 1'b0; i_ready = 1'b0;
        chk("wrap_accepts", acc_idx.size(), 32'd4);
        for (int k = 1; k < acc_idx.size(); k++)
            chk("accept_spacing", acc_idx[k] - acc_idx[k-1], 32'd4);
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
